// File: rtl/aes_ctr_block_packer.sv
// rtl/aes_ctr_block_packer.sv - packs a plaintext byte stream into 128-bit blocks behind a small block FIFO
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   byte_in/valid     plaintext byte stream in; byte_ready back-pressures the source
//   flush             1-cycle pulse closing the current partial block as last
//   blk_data          FIFO head block, first byte received in [127:120]
//   blk_nbytes        valid bytes in blk_data (1..16)
//   blk_last          block was closed by flush
//   blk_valid/ready   FIFO head handshake toward the encryption core
//   blk_count         blocks popped since reset, wrapping
module aes_ctr_block_packer #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    input  logic         flush,
    output logic [127:0] blk_data,
    output logic [4:0]   blk_nbytes,
    output logic         blk_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [31:0]  blk_count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [127:0]     PAD_FILL = {16{PAD_BYTE}};

    typedef enum logic {FILL, FLUSH_WAIT} state_t;

    state_t         state, state_next;
    logic [3:0]     cnt, cnt_next;
    logic [127:0]   fill, fill_next;
    logic [127:0]   fill_with_byte;
    logic           running;

    logic [127:0]   mem_data   [FIFO_DEPTH];
    logic [4:0]     mem_nbytes [FIFO_DEPTH];
    logic           mem_last   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic           accept, pop, push;
    logic [127:0]   push_data;
    logic [4:0]     push_nbytes;
    logic           push_last;

    // running holds byte_ready low while reset is asserted and releases it
    // on the first clock after reset, keeping byte_ready purely registered.
    assign byte_ready = running && (state == FILL) && (fifo_count < DEPTH_C);
    assign accept     = byte_valid && byte_ready;
    assign blk_valid  = (fifo_count != '0);
    assign pop        = blk_valid && blk_ready;
    assign blk_data   = blk_valid ? mem_data[rd_ptr]   : '0;
    assign blk_nbytes = blk_valid ? mem_nbytes[rd_ptr] : '0;
    assign blk_last   = blk_valid ? mem_last[rd_ptr]   : 1'b0;

    // Unwritten bytes of fill always hold PAD_BYTE, so a flushed partial
    // block is simply the fill register as it stands.
    always_comb begin
        fill_with_byte = fill;
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'(i)) begin
                fill_with_byte[127-8*i -: 8] = byte_in;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        fill_next   = fill;
        push        = 1'b0;
        push_data   = fill_with_byte;
        push_nbytes = {1'b0, cnt} + 5'd1;
        push_last   = flush;
        case (state)
            FILL: begin
                if (accept) begin
                    if (cnt == 4'd15 || flush) begin
                        push      = 1'b1;
                        cnt_next  = 4'd0;
                        fill_next = PAD_FILL;
                    end else begin
                        cnt_next  = cnt + 4'd1;
                        fill_next = fill_with_byte;
                    end
                end else if (flush && cnt != 4'd0) begin
                    if (fifo_count == DEPTH_C) begin
                        state_next = FLUSH_WAIT;
                    end else begin
                        push        = 1'b1;
                        push_data   = fill;
                        push_nbytes = {1'b0, cnt};
                        push_last   = 1'b1;
                        cnt_next    = 4'd0;
                        fill_next   = PAD_FILL;
                    end
                end
            end
            FLUSH_WAIT: begin
                // fifo_count is registered, so a slot freed by a pop is seen
                // one cycle later and the pending block goes in on that edge.
                if (fifo_count != DEPTH_C) begin
                    push        = 1'b1;
                    push_data   = fill;
                    push_nbytes = {1'b0, cnt};
                    push_last   = 1'b1;
                    cnt_next    = 4'd0;
                    fill_next   = PAD_FILL;
                    state_next  = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            cnt        <= 4'd0;
            fill       <= PAD_FILL;
            running    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            blk_count  <= 32'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            fill    <= fill_next;
            running <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                blk_count <= blk_count + 32'd1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]   <= push_data;
            mem_nbytes[wr_ptr] <= push_nbytes;
            mem_last[wr_ptr]   <= push_last;
        end
    end
endmodule

// File: tb/tb_aes_ctr_block_packer.sv
// tb/tb_aes_ctr_block_packer.sv - scoreboard bench for aes_ctr_block_packer
module tb_aes_ctr_block_packer;
    localparam logic [7:0] PAD = 8'h00;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         flush;
    logic [127:0] blk_data;
    logic [4:0]   blk_nbytes;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [31:0]  blk_count;

    aes_ctr_block_packer #(.FIFO_DEPTH(2), .PAD_BYTE(PAD)) dut (
        .clk(clk), .reset(reset),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .flush(flush),
        .blk_data(blk_data), .blk_nbytes(blk_nbytes), .blk_last(blk_last),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [4:0]   n;
        logic         l;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] part[$];
    int         total = 0;
    int         bad   = 0;
    int         mon_pops = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h need %h", name, act, req);
        end
    endtask

    // Reference: blocks are the accepted byte sequence cut every 16 bytes or
    // at a flush, padded out to 16 bytes.
    function automatic void close_block(input bit last);
        exp_t e;
        e.d = '0;
        for (int i = 0; i < 16; i++) begin
            e.d = {e.d[119:0], (i < part.size()) ? part[i] : PAD};
        end
        e.n = 5'(part.size());
        e.l = last;
        exp_q.push_back(e);
        part.delete();
    endfunction

    function automatic void model(input bit acc, input logic [7:0] b, input bit fl);
        if (acc) begin
            part.push_back(b);
            if (part.size() == 16) close_block(fl);
            else if (fl) close_block(1'b1);
        end else if (fl && part.size() > 0) begin
            close_block(1'b1);
        end
    endfunction

    task automatic cycle(input bit v, input logic [7:0] b, input bit fl, input bit rdy, output bit acc);
        @(negedge clk);
        byte_valid = v;
        byte_in    = b;
        flush      = fl;
        blk_ready  = rdy;
        #1;
        acc = v && byte_ready;
        model(acc, b, fl);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fl, input bit rdy);
        bit acc;
        int k;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 200) begin
            cycle(1'b1, b, (k == 0) ? fl : 1'b0, rdy, acc);
            k++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept need accept of %h", b);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        byte_valid = 1'b0;
        flush      = 1'b0;
        blk_ready  = 1'b0;
        part.delete();
        exp_q.delete();
        mon_pops = 0;
        #1;
        check("rst_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_blk_count", 128'(blk_count), 128'd0);
        check("rst_byte_ready", 128'(byte_ready), 128'd0);
        check("rst_blk_data", blk_data, 128'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every handshake on the block port pops one expected block.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && blk_valid && blk_ready) begin
                check("blk_count_pre", 128'(blk_count), 128'(mon_pops));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_block: got %h need none", blk_data);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.d);
                    check("blk_nbytes", 128'(blk_nbytes), 128'(e.n));
                    check("blk_last", 128'(blk_last), 128'(e.l));
                end
                mon_pops++;
            end
        end
    end

    initial begin
        bit acc;
        bit pend;
        logic [7:0] pb;
        int k;
        reset = 1'b1;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        flush = 1'b0;
        blk_ready = 1'b0;
        apply_reset();
        idle(1, 1'b1);
        check("ready_after_reset", 128'(byte_ready), 128'd1);

        // 00..0F back to back, valid one cycle after the 16th accept
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b1);
        check("t1_valid_at_accept", 128'(blk_valid), 128'd0);
        idle(1, 1'b1);
        check("t1_valid_latency", 128'(blk_valid), 128'd1);

        // partial block closed by flush
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'hBB, 1'b0, 1'b1);
        send_byte(8'hCC, 1'b0, 1'b1);
        send_byte(8'hDD, 1'b0, 1'b1);
        send_byte(8'hEE, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        idle(3, 1'b1);

        // back-pressure: 32 bytes fill the FIFO, then the source stalls
        for (int i = 0; i < 32; i++) send_byte(8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h60, 1'b0, 1'b0, acc);
        check("t3_ready_full", 128'(byte_ready), 128'd0);
        cycle(1'b1, 8'h60, 1'b0, 1'b0, acc);
        check("t3_still_full", 128'(acc), 128'd0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i), 1'b0, 1'b1);
        idle(2, 1'b1);
        check("t3_blk_count", 128'(blk_count), 128'd4);

        // flush of the 8 leftover bytes, then a flush with nothing pending
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        idle(2, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);
        idle(3, 1'b1);
        check("t5_empty_flush", 128'(blk_count), 128'd5);
        check("t5_no_extra_valid", 128'(blk_valid), 128'd0);
        for (int i = 0; i < 15; i++) send_byte(8'(8'h80 + i), 1'b0, 1'b1);
        send_byte(8'h8F, 1'b1, 1'b1);
        idle(3, 1'b1);
        check("t5_blk_count", 128'(blk_count), 128'd6);

        // reset with one block queued and 7 bytes in the fill register
        for (int i = 0; i < 23; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0);
        apply_reset();
        idle(1, 1'b1);
        check("t6_valid_after_reset", 128'(blk_valid), 128'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 + i), 1'b0, 1'b1);
        idle(3, 1'b1);
        check("t6_blk_count", 128'(blk_count), 128'd1);

        // randomized traffic with sporadic flushes and consumer stalls
        pend = 1'b0;
        pb = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pb = 8'($urandom);
            end
            cycle(pend, pb, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, acc);
            if (acc) pend = 1'b0;
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1, acc);

        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            idle(1, 1'b1);
            k++;
        end
        idle(2, 1'b1);
        check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
        check("drain_valid_low", 128'(blk_valid), 128'd0);
        check("drain_blk_count", 128'(blk_count), 128'(mon_pops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
